// File: rtl/user_demux_pkg.sv
// Shared types and constants for the user return-path demultiplexer.
// Holds the lynx-side data and length widths, the FSM state encoding and
// the {id, n_tr} sequence entry that the arbiter and the demux both use.
package user_demux_pkg;

    // Local copy of the lynxTypes widths this block depends on
    localparam int AXI_DATA_BITS = 64;
    localparam int LEN_BITS      = 28;
    localparam int N_OUTSTANDING = 8;

    // Field widths of a sequence entry in the default two-cpid build
    localparam int DEF_N_CPID    = 2;
    localparam int DEF_ID_BITS   = $clog2(DEF_N_CPID);
    localparam int DEF_BLEN_BITS = LEN_BITS - $clog2(AXI_DATA_BITS / 8);

    // Sequence entry: id in the upper bits, beats-minus-one below it.
    // Field order is shared with the arbiter; the demux slices its mux
    // input in exactly this order.
    typedef struct packed {
        logic [DEF_ID_BITS-1:0]   id;
        logic [DEF_BLEN_BITS-1:0] n_tr;
    } user_seq_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } demux_state_t;

endpackage

// File: rtl/user_demux.sv
// user_demux: steers the shared return data stream to per-cpid AXI4-Stream
// outputs. Each {id, n_tr} entry taken from the arbiter sequence stream
// routes exactly n_tr+1 beats to cpid id; output tlast comes from the beat
// counter. The data path is purely combinational, so backpressure is
// passed straight through beat for beat.
// Optional build macro: USER_DEMUX_LAST_CHECK_EN adds a sticky err_last
// flag that records any disagreement between input tlast and the counter.
module user_demux
    import user_demux_pkg::*;
#(
    parameter  int N_CPID      = 2,
    parameter  int BLEN_BITS   = LEN_BITS - $clog2(AXI_DATA_BITS / 8),
    localparam int N_CPID_BITS = $clog2(N_CPID),
    localparam int SEQ_BITS    = N_CPID_BITS + BLEN_BITS,
    localparam int KEEP_BITS   = AXI_DATA_BITS / 8
) (
    input  logic                                    aclk,
    input  logic                                    areset,

    // Sequence entries {id, n_tr} from the arbiter
    input  logic                                    mux_valid,
    output logic                                    mux_ready,
    input  logic [SEQ_BITS-1:0]                     mux_data,

    // Shared incoming data stream
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic [AXI_DATA_BITS-1:0]                s_axis_tdata,
    input  logic [KEEP_BITS-1:0]                    s_axis_tkeep,
    input  logic                                    s_axis_tlast,

    // Per-cpid output streams
    output logic [N_CPID-1:0]                       m_axis_tvalid,
    input  logic [N_CPID-1:0]                       m_axis_tready,
    output logic [N_CPID-1:0][AXI_DATA_BITS-1:0]    m_axis_tdata,
    output logic [N_CPID-1:0][KEEP_BITS-1:0]        m_axis_tkeep,
    output logic [N_CPID-1:0]                       m_axis_tlast,

    output logic                                    err_last
);

    localparam logic [N_CPID_BITS:0] N_CPID_L = (N_CPID_BITS + 1)'(N_CPID);

    demux_state_t             r_state;
    logic [N_CPID_BITS-1:0]   r_id;
    logic [BLEN_BITS-1:0]     r_cnt;

    logic                     w_active;
    logic                     w_in_range;
    logic                     w_sink_rdy;
    logic                     w_last;
    logic                     w_beat;
    logic [N_CPID_BITS-1:0]   w_mux_id;
    logic [BLEN_BITS-1:0]     w_mux_ntr;

    // Entry fields, upper bits id and lower bits beats-minus-one
    assign w_mux_id  = mux_data[SEQ_BITS-1:BLEN_BITS];
    assign w_mux_ntr = mux_data[BLEN_BITS-1:0];

    // Beat qualification: an out-of-range id behaves as an always-ready sink
    // so its beats drain without reaching any output
    always_comb begin
        w_active   = (r_state == ST_ACTIVE) && !areset;
        w_in_range = ({1'b0, r_id} < N_CPID_L);
        w_sink_rdy = w_in_range ? m_axis_tready[r_id] : 1'b1;
        w_last     = (r_cnt == '0);
        w_beat     = w_active && s_axis_tvalid && w_sink_rdy;
    end

    assign s_axis_tready = w_active && w_sink_rdy;

    // A new entry is taken when idle, or together with the last beat of the
    // current transfer so consecutive transfers run without a bubble
    assign mux_ready = !areset && ((r_state == ST_IDLE) || (w_beat && w_last));

    // Output routing: only the selected in-range lane raises tvalid
    always_comb begin
        for (int i = 0; i < N_CPID; i++) begin
            m_axis_tvalid[i] = w_active && w_in_range && s_axis_tvalid &&
                               (r_id == N_CPID_BITS'(i));
            m_axis_tdata[i]  = s_axis_tdata;
            m_axis_tkeep[i]  = s_axis_tkeep;
            m_axis_tlast[i]  = w_last;
        end
    end

    // Sequencing FSM with the selected id and remaining-beat counter
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mux_valid) begin
                        r_id    <= w_mux_id;
                        r_cnt   <= w_mux_ntr;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_beat) begin
                        if (!w_last) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (mux_valid) begin
                            r_id  <= w_mux_id;
                            r_cnt <= w_mux_ntr;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef USER_DEMUX_LAST_CHECK_EN
    logic r_err_last;

    // Sticky flag: input tlast disagreed with the counter on an accepted beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_last <= 1'b0;
        end else if (w_beat && (s_axis_tlast != w_last)) begin
            r_err_last <= 1'b1;
        end
    end

    assign err_last = r_err_last;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = s_axis_tlast;
    assign err_last       = 1'b0;
`endif

endmodule

// File: doc/user_demux.md
# user_demux

Return-path demultiplexer for the per-cpid user request arbiter. It consumes the arbiter's sequence stream of `{id, n_tr}` entries, one per granted request. It then steers the shared incoming data stream beat-by-beat to the per-cpid AXI4-Stream outputs, delivering exactly `n_tr+1` beats to cpid `id` before taking the next entry. It sits between the shared data channel and the `N_CPID` user-logic sinks.

## Interface
Parameters:
- `N_CPID`, default 2: number of cpid output streams; must be ≥ 2.
- `N_CPID_BITS`, default `$clog2(N_CPID)`: width of the id field (localparam).
- `BLEN_BITS`, default `LEN_BITS - $clog2(AXI_DATA_BITS/8)`: width of the beat-count field (localparam).

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- `aclk`  in  1  clock.
- `areset`  in  1  synchronous active-high reset.
- `mux`  metaIntf.s  `N_CPID_BITS+BLEN_BITS`  sequence entry `{id, n_tr}`; `n_tr` is beats-minus-one.
- `s_axis`  AXI4S.s  `AXI_DATA_BITS` (+keep/last)  shared data input.
- `m_axis[N_CPID]`  AXI4S.m  `AXI_DATA_BITS` (+keep/last)  per-cpid outputs.
- `err_last`  out  1  sticky tlast-mismatch flag; see Configuration.

## Operation
- FSM states: IDLE and ACTIVE. Registers: `id_r[N_CPID_BITS]` and `cnt_r[BLEN_BITS]`.
- IDLE:
  - `mux.ready=1`, `s_axis.tready=0`, all `m_axis[*].tvalid=0`.
  - On a `mux` handshake, load `id_r` and `cnt_r` from `{id, n_tr}`, then go to ACTIVE.
- ACTIVE, combinational routing:
  - `m_axis[id_r].tvalid = s_axis.tvalid`.
  - `s_axis.tready = m_axis[id_r].tready`.
  - `tdata` and `tkeep` pass through to `m_axis[id_r]`; all other outputs hold `tvalid=0`.
- Output tlast is `(cnt_r==0)`, derived from the counter. The input tlast is not forwarded.
- Beat handshake with `cnt_r != 0`: `cnt_r` decrements by 1.
- Beat handshake with `cnt_r == 0` (last beat):
  - If `mux.valid`, the next entry is loaded in the same cycle and the FSM stays in ACTIVE (zero-bubble).
  - Otherwise the FSM goes to IDLE.
  - `mux.ready` = `s_axis.tvalid & m_axis[id_r].tready & (cnt_r==0)` in ACTIVE.
- Out-of-range id (`id_r >= N_CPID`, only possible for non-power-of-2 `N_CPID`):
  - `s_axis.tready=1`; beats are consumed and dropped.
  - The counter still runs.
  - No output asserts tvalid.
- `n_tr = 0` is a legal single-beat transfer.
- `n_tr = 2^BLEN_BITS-1` gives the maximum transfer; the counter never wraps below 0.

## Timing
- Data path is fully combinational: zero-cycle latency from `s_axis` to `m_axis`. There is no storage, so backpressure is honoured beat-exact.
- One cycle from a `mux` handshake in IDLE until the first beat can move.
- Back-to-back entries: no idle cycle between the last beat of one transfer and the first beat of the next.
- Under reset (`areset=1`):
  - FSM goes to IDLE; `id_r=0`, `cnt_r=0`, `err_last=0`.
  - While reset is asserted: `mux.ready=0`, `s_axis.tready=0`, all `m_axis.tvalid=0`.
- Reset mid-transfer abandons the remaining beats. Upstream is reset together with this block.
- AXI rules on outputs: tvalid, tdata, tkeep and tlast stay stable while `tvalid & !tready`, because they are inherited from `s_axis` and its rules.

## Configuration
- `USER_DEMUX_LAST_CHECK_EN` defined:
  - On every accepted beat, compare `s_axis.tlast` with `(cnt_r==0)`.
  - On a mismatch, set `err_last` sticky until reset.
  - Routing is unaffected.
- Undefined: `err_last` is tied to 0 and no compare logic is built.

## Structure
- `lynxTypes` supplies `AXI_DATA_BITS`, `LEN_BITS` and `N_OUTSTANDING`.
- Add a packed sequence-entry typedef `user_seq_t` (`id`, `n_tr`) to the package, shared with the arbiter so both ends agree on field order.
- No sub-module: the FSM, counter and mux are small enough for a single module.
- Upstream sequence buffering (`queue_meta`) lives at the arbiter side, not here.

## Test plan
- Single entry `{id=1, n_tr=3}` and 4 input beats:
  - `m_axis[1]` gets 4 beats with tlast only on the 4th.
  - `m_axis[0].tvalid` stays 0.
  - FSM returns to IDLE.
- Entries `{0,0}` and `{1,1}` preloaded, continuous input: beats 0, 1, 2 go to cpid 0, 1, 1 on consecutive cycles with no bubble.
- `{id=0, n_tr=2}` with `m_axis[0].tready` toggled 1,0,0,1,1: `s_axis.tready` mirrors it, data is held stable, and exactly 3 beats are delivered.
- `N_CPID=3`, entry `{id=3, n_tr=1}`: 2 beats are consumed with `tready=1` and all outputs stay quiet.
- Reset asserted after 2 of 5 beats of `{0,4}`:
  - Outputs go idle in the next cycle and `mux.ready=0` during reset.
  - After reset the FSM is in IDLE with `cnt_r=0`.
- With `USER_DEMUX_LAST_CHECK_EN` defined, `{0,2}` with input tlast on beat 2 instead of beat 3: `err_last` rises after beat 2 and stays 1 until reset.
